psum_drain: RTL and testbench

- Downstream consumer of a superblock row's partial-sum read port.
- The row's columns return psum data skewed by one clk_l cycle per column (column c lags column 0 by c cycles). This block deskews the columns into one row word and buffers rows in a FIFO.
- It then serialises one column word per beat onto a valid/ready stream toward the output/writeback path.
- It raises a stall toward the superblock controller before the FIFO can overflow.

---
 rtl/sblk_pkg.sv | 35 +++
 rtl/psum_row_fifo.sv | 73 +++++++
 rtl/psum_drain.sv | 219 +++++++++++++++++++++
 tb/tb_psum_drain.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// -----------------------------------------------------------------------------
// sblk_pkg
// Shared types for the superblock psum drain path.
//   - col_word_t    : one column word (two psum halves)
//   - psum_row_t    : one deskewed row (all column words + last-of-tile flag)
//   - drain_state_e : serialiser states
// Default sizing constants are used as the parameter defaults of psum_drain;
// the row typedefs follow these constants, so an instance that overrides
// N_COLUMN / WID_PSUM must be paired with matching package values.
// -----------------------------------------------------------------------------
package sblk_pkg;

    localparam int SBLK_N_COLUMN     = 4;
    localparam int SBLK_WID_PSUM     = 32;
    localparam int SBLK_FIFO_DEPTH   = 8;
    localparam int SBLK_STALL_MARGIN = 4;

    typedef logic [2*SBLK_WID_PSUM-1:0] col_word_t;

    typedef struct packed {
        logic                               last;
        col_word_t [SBLK_N_COLUMN-1:0]      data;
    } psum_row_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    // Width that holds FIFO occupancy plus every row still in the deskew pipe.
    function automatic int occ_width(input int depth, input int ncol);
        return $clog2(depth + ncol) + 1;
    endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// -----------------------------------------------------------------------------
// psum_row_fifo
// Generic synchronous FIFO with occupancy count and first-word-fall-through
// read data (pop_data_o always shows the head entry).
// Ports:
//   clk_l, rst_n   clock, async active-low reset (pointers/count only)
//   push_i         write request; accepted when not full or when a pop
//                  happens in the same cycle
//   push_data_i    write data
//   pop_i          read request (ignored when empty)
//   pop_data_o     head entry
//   empty_o        no entries
//   count_o        number of entries, 0..DEPTH
//   drop_o         push_i was refused this cycle (FIFO full, no pop)
// -----------------------------------------------------------------------------
module psum_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i & (~full | pop_ok);
    assign drop_o  = push_i & ~push_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; only pointers define validity.
    always_ff @(posedge clk_l) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Consumes a superblock row's skewed psum read port, deskews the columns into
// one row, buffers rows in a FIFO and serialises one column word per beat on a
// valid/ready stream. Raises drain_stall before the FIFO can overflow.
// Ports:
//   clk_l, rst_n   clock, async active-low reset
//   psum_rd_data   row psum bus, column c at [2*WID_PSUM*c +: 2*WID_PSUM];
//                  column c arrives c cycles after column 0
//   psum_rd_vld    column-0 valid
//   psum_rd_last   last row of tile (qualified by psum_rd_vld)
//   drain_stall    registered; controller must stop issuing psum reads
//   out_data       serialised column word
//   out_col        column index of out_data
//   out_last       last beat of a last-flagged row
//   out_vld/out_rdy output handshake
//   status_drain   block busy
//   ovf_err        sticky: a row was dropped on a full FIFO
// -----------------------------------------------------------------------------
module psum_drain
    import sblk_pkg::*;
#(
    parameter int N_COLUMN     = SBLK_N_COLUMN,
    parameter int WID_PSUM     = SBLK_WID_PSUM,
    parameter int FIFO_DEPTH   = SBLK_FIFO_DEPTH,
    parameter int STALL_MARGIN = SBLK_STALL_MARGIN,
    parameter int WID_COL      = $clog2(N_COLUMN)
) (
    input  logic                             clk_l,
    input  logic                             rst_n,
    input  logic [2*WID_PSUM*N_COLUMN-1:0]   psum_rd_data,
    input  logic                             psum_rd_vld,
    input  logic                             psum_rd_last,
    output logic                             drain_stall,
    output logic [2*WID_PSUM-1:0]            out_data,
    output logic [WID_COL-1:0]               out_col,
    output logic                             out_last,
    output logic                             out_vld,
    input  logic                             out_rdy,
    output logic                             status_drain,
    output logic                             ovf_err
);

    localparam int CW      = 2 * WID_PSUM;
    localparam int ROW_W   = $bits(psum_row_t);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = occ_width(FIFO_DEPTH, N_COLUMN);
    localparam logic [WID_COL-1:0] LAST_COL = WID_COL'(N_COLUMN - 1);

    // ------------------------------------------------------------------ deskew
    // vld/last ride an (N_COLUMN-1)-stage pipe; when the tail is valid, every
    // column's delayed word lines up with column N_COLUMN-1 on the bus.
    logic [N_COLUMN-1:1] vld_pipe_q, last_pipe_q;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q[1]  <= psum_rd_vld;
            last_pipe_q[1] <= psum_rd_vld & psum_rd_last;
            for (int s = 2; s < N_COLUMN; s++) begin
                vld_pipe_q[s]  <= vld_pipe_q[s-1];
                last_pipe_q[s] <= last_pipe_q[s-1];
            end
        end
    end

    col_word_t [N_COLUMN-1:0] row_cols;

    // Column c is delayed by N_COLUMN-1-c registers.
    for (genvar c = 0; c < N_COLUMN - 1; c++) begin : g_dly
        localparam int D = N_COLUMN - 1 - c;
        col_word_t [D-1:0] dly_q;

        always_ff @(posedge clk_l or negedge rst_n) begin
            if (!rst_n) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= psum_rd_data[CW*c +: CW];
                for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
            end
        end

        assign row_cols[c] = dly_q[D-1];
    end

    assign row_cols[N_COLUMN-1] = psum_rd_data[CW*(N_COLUMN-1) +: CW];

    psum_row_t push_row;
    assign push_row.last = last_pipe_q[N_COLUMN-1];
    assign push_row.data = row_cols;

    // -------------------------------------------------------------------- FIFO
    logic                fifo_pop, fifo_empty, fifo_drop;
    logic [FIFO_AW:0]    fifo_count;
    logic [ROW_W-1:0]    fifo_rd_raw;
    psum_row_t           fifo_rd;

    psum_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l       (clk_l),
        .rst_n       (rst_n),
        .push_i      (vld_pipe_q[N_COLUMN-1]),
        .push_data_i (push_row),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_raw),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .drop_o      (fifo_drop)
    );

    assign fifo_rd = fifo_rd_raw;

    // ------------------------------------------------------------ stall / error
    // Rows still in the deskew pipe will land in the FIFO regardless of stall,
    // so they count toward occupancy.
    logic [OCC_W-1:0] occ;
    logic             drain_stall_q, drain_stall_d;
    logic             ovf_q;

    always_comb begin
        occ = OCC_W'(fifo_count);
        for (int s = 1; s < N_COLUMN; s++) occ = occ + OCC_W'(vld_pipe_q[s]);
        drain_stall_d = (occ >= OCC_W'(FIFO_DEPTH - STALL_MARGIN));
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            drain_stall_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            drain_stall_q <= drain_stall_d;
            ovf_q         <= ovf_q | fifo_drop;
        end
    end

    // -------------------------------------------------------------- serialiser
    // The row is held in a shift register; column 0 of the register is always
    // the current beat, so out_data comes straight from a flop.
    drain_state_e             state_q, state_d;
    col_word_t [N_COLUMN-1:0] sr_q, sr_d;
    logic [WID_COL-1:0]       col_q, col_d;
    logic                     row_last_q, row_last_d;
    logic                     olast_q, olast_d;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        col_d      = col_q;
        row_last_d = row_last_q;
        olast_d    = olast_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sr_d       = fifo_rd.data;
                    row_last_d = fifo_rd.last;
                    col_d      = '0;
                    olast_d    = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    if (col_q == LAST_COL) begin
                        if (!fifo_empty) begin
                            // Back-to-back rows: load the next row without a bubble.
                            fifo_pop   = 1'b1;
                            sr_d       = fifo_rd.data;
                            row_last_d = fifo_rd.last;
                            col_d      = '0;
                            olast_d    = 1'b0;
                        end else begin
                            olast_d    = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        for (int i = 0; i < N_COLUMN - 1; i++) sr_d[i] = sr_q[i+1];
                        sr_d[N_COLUMN-1] = '0;
                        col_d   = col_q + WID_COL'(1);
                        olast_d = row_last_q & ((col_q + WID_COL'(1)) == LAST_COL);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            col_q      <= '0;
            row_last_q <= 1'b0;
            olast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            col_q      <= col_d;
            row_last_q <= row_last_d;
            olast_q    <= olast_d;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign out_vld      = (state_q == SEND);
    assign out_data     = sr_q[0];
    assign out_col      = col_q;
    assign out_last     = olast_q;
    assign drain_stall  = drain_stall_q;
    assign ovf_err      = ovf_q;
    assign status_drain = (|vld_pipe_q) | ~fifo_empty | (state_q == SEND);

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
// Directed scenarios plus a randomized phase for psum_drain. Expected values
// come from a queue-based reference model: issued rows wait in a pending list
// until their push cycle, then move through a row queue and are emitted one
// column per accepted beat.
// -----------------------------------------------------------------------------
module tb_psum_drain;

    localparam int NC     = 4;
    localparam int WP     = 32;
    localparam int CW     = 2 * WP;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 4;
    localparam int WC     = $clog2(NC);

    logic                 clk_l = 1'b0;
    logic                 rst_n = 1'b1;
    logic [CW*NC-1:0]     psum_rd_data = '0;
    logic                 psum_rd_vld  = 1'b0;
    logic                 psum_rd_last = 1'b0;
    logic                 drain_stall;
    logic [CW-1:0]        out_data;
    logic [WC-1:0]        out_col;
    logic                 out_last;
    logic                 out_vld;
    logic                 out_rdy = 1'b0;
    logic                 status_drain;
    logic                 ovf_err;

    always #5 clk_l = ~clk_l;

    psum_drain #(
        .N_COLUMN     (NC),
        .WID_PSUM     (WP),
        .FIFO_DEPTH   (DEPTH),
        .STALL_MARGIN (MARGIN),
        .WID_COL      (WC)
    ) dut (
        .clk_l        (clk_l),
        .rst_n        (rst_n),
        .psum_rd_data (psum_rd_data),
        .psum_rd_vld  (psum_rd_vld),
        .psum_rd_last (psum_rd_last),
        .drain_stall  (drain_stall),
        .out_data     (out_data),
        .out_col      (out_col),
        .out_last     (out_last),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .status_drain (status_drain),
        .ovf_err      (ovf_err)
    );

    typedef logic [NC-1:0][CW-1:0] brow_t;
    typedef struct { brow_t d; bit last; } mrow_t;
    typedef struct { mrow_t r; int due; } pend_t;

    // reference model state
    mrow_t m_fifo[$];
    pend_t m_pend[$];
    bit    m_v, m_ovf, m_stall;
    mrow_t m_cur;
    int    m_col;
    int    ecnt;

    brow_t drv_r [NC];   // drv_r[k] = row issued k cycles ago (column k is due now)

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        m_pend.delete();
        m_v = 0; m_ovf = 0; m_stall = 0; m_col = 0;
    endtask

    // One clock edge of the reference behaviour, using the pre-edge inputs.
    task automatic model_step(input bit vld, input bit last, input bit rdy, input brow_t nr);
        bit    stall_n, pop, has_push, can;
        pend_t pe;
        ecnt++;
        stall_n  = (m_fifo.size() + m_pend.size()) >= (DEPTH - MARGIN);
        pop      = 0;
        has_push = 0;
        can      = 0;
        if (!m_v) begin
            pop = (m_fifo.size() > 0);
        end else if (rdy) begin
            if (m_col == NC - 1) begin
                if (m_fifo.size() > 0) pop = 1;
                else m_v = 0;
            end else begin
                m_col++;
            end
        end
        if (m_pend.size() > 0 && m_pend[0].due == ecnt) begin
            pe       = m_pend.pop_front();
            has_push = 1;
            can      = (m_fifo.size() < DEPTH) || pop;
        end
        if (pop) begin
            m_cur = m_fifo.pop_front();
            m_col = 0;
            m_v   = 1;
        end
        if (has_push) begin
            if (can) m_fifo.push_back(pe.r);
            else m_ovf = 1;
        end
        if (vld) begin
            pe.r.d    = nr;
            pe.r.last = last;
            pe.due    = ecnt + NC - 1;
            m_pend.push_back(pe);
        end
        m_stall = stall_n;
    endtask

    task automatic check_outputs();
        chk("out_vld", 64'(out_vld), 64'(m_v));
        if (m_v) begin
            chk("out_data", out_data, m_cur.d[m_col]);
            chk("out_col", 64'(out_col), 64'(m_col));
            chk("out_last", 64'(out_last), 64'(m_cur.last && (m_col == NC - 1)));
        end
        chk("drain_stall", 64'(drain_stall), 64'(m_stall));
        chk("status_drain", 64'(status_drain),
            64'((m_pend.size() > 0) || (m_fifo.size() > 0) || m_v));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    endtask

    // Drive one cycle: issue a row (skewed over the bus) if vld, then clock.
    task automatic cyc(input bit vld, input bit last, input bit rdy, input bit dir = 1'b0);
        brow_t nr;
        for (int c = 0; c < NC; c++)
            nr[c] = dir ? (64'hC0DE_0000 | 64'(c)) : {$urandom(), $urandom()};
        for (int c = NC - 1; c > 0; c--) drv_r[c] = drv_r[c-1];
        drv_r[0] = nr;
        for (int c = 0; c < NC; c++) psum_rd_data[c*CW +: CW] = drv_r[c][c];
        psum_rd_vld  = vld;
        psum_rd_last = vld ? last : 1'($urandom_range(0, 1));
        out_rdy      = rdy;
        @(posedge clk_l);
        model_step(vld, vld & last, rdy, nr);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        psum_rd_vld = 1'b0;
        out_rdy     = 1'b0;
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_col", 64'(out_col), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_drain_stall", 64'(drain_stall), 64'(0));
        chk("rst_status", 64'(status_drain), 64'(0));
        chk("rst_ovf", 64'(ovf_err), 64'(0));
        model_clear();
        repeat (2) @(posedge clk_l);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int first, nb, fb, lb;
        bit found;
        for (int c = 0; c < NC; c++) drv_r[c] = '0;
        ecnt = 0;
        model_clear();
        #2;
        do_reset();

        // Single directed row, last=1: latency and beat order.
        first = -1;
        cyc(1, 1, 1, 1);
        if (out_vld && first < 0) first = 1;
        for (int j = 2; j <= 14; j++) begin
            cyc(0, 0, 1);
            if (out_vld && first < 0) first = j;
        end
        chk("s1_latency", 64'(first), 64'(5));
        chk("s1_idle_status", 64'(status_drain), 64'(0));

        // Three back-to-back rows: 12 beats without a bubble.
        nb = 0; fb = -1; lb = -1;
        for (int j = 0; j < 23; j++) begin
            cyc(j < 3, 0, 1);
            if (out_vld) begin
                nb++;
                if (fb < 0) fb = j;
                lb = j;
            end
        end
        chk("s2_beats", 64'(nb), 64'(12));
        chk("s2_contiguous", 64'(lb - fb + 1), 64'(12));

        // Backpressure: stall rises, outputs hold, then drain in order.
        for (int j = 0; j < 6; j++) cyc(1, 1'($urandom_range(0, 1)), 0);
        for (int j = 0; j < 4; j++) cyc(0, 0, 0);
        chk("s3_stall", 64'(drain_stall), 64'(1));
        chk("s3_hold_col", 64'(out_col), 64'(0));
        for (int j = 0; j < 60; j++) cyc(0, 0, 1'($urandom_range(0, 3) != 0));
        chk("s3_drained", 64'(status_drain), 64'(0));
        chk("s3_stall_off", 64'(drain_stall), 64'(0));

        // Overflow: ignore stall with output blocked.
        for (int j = 0; j < 10; j++) cyc(1, 0, 0);
        for (int j = 0; j < 6; j++) cyc(0, 0, 0);
        chk("s4_ovf_set", 64'(ovf_err), 64'(1));
        for (int j = 0; j < 50; j++) cyc(0, 0, 1);
        chk("s4_ovf_sticky", 64'(ovf_err), 64'(1));
        chk("s4_drained", 64'(status_drain), 64'(0));

        // Full FIFO: push lands on the same edge as the last-beat pop.
        do_reset();
        for (int j = 0; j < 9; j++) cyc(1, 0, 0);
        for (int j = 0; j < 6; j++) cyc(0, 0, 0);
        cyc(1, 1, 1);
        for (int j = 0; j < 3; j++) cyc(0, 0, 1);
        chk("s5_no_ovf", 64'(ovf_err), 64'(0));
        for (int j = 0; j < 50; j++) cyc(0, 0, 1);
        chk("s5_no_ovf_end", 64'(ovf_err), 64'(0));
        chk("s5_drained", 64'(status_drain), 64'(0));

        // Random traffic honouring drain_stall, random backpressure.
        for (int j = 0; j < 200; j++)
            cyc(!drain_stall && ($urandom_range(0, 1) == 1),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        for (int j = 0; j < 60; j++) cyc(0, 0, 1);
        chk("s6_drained", 64'(status_drain), 64'(0));

        // Reset in the middle of a row.
        found = 0;
        cyc(1, 1, 1);
        cyc(1, 0, 1);
        for (int j = 0; j < 20 && !found; j++) begin
            cyc(0, 0, 1);
            if (out_vld && out_col == WC'(1)) found = 1;
        end
        chk("s7_reached_beat2", 64'(found), 64'(1));
        do_reset();
        for (int j = 0; j < 10; j++) cyc(0, 0, 1);
        chk("s7_vld_after", 64'(out_vld), 64'(0));
        chk("s7_status_after", 64'(status_drain), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
